// File: rtl/wdt_pkg.sv
// Shared types and register map for the watchdog controller.
// WDT_WINDOW_EN adds the WINDOW register (window-kick check).
package wdt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WARN = 2'd2,
    BITE = 2'd3
  } wdt_state_e;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_PRESC  = 5'h04;
  localparam logic [4:0] ADDR_LOAD   = 5'h08;
  localparam logic [4:0] ADDR_KICK   = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_COUNT  = 5'h14;
  localparam logic [4:0] ADDR_WINDOW = 5'h18;

  localparam logic [31:0] KICK_KEY_DEF = 32'h5A5A_A5A5;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_LOCK_BIT   = 1;
  localparam int STAT_STATE_LSB  = 0;
  localparam int STAT_BADKEY_BIT = 2;

endpackage

// File: rtl/wdt_prescaler.sv
// Tick generator: one tick every i_div+1 cycles, restartable via i_clr.
module wdt_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               i_clr,
  input  logic [PRESC_W-1:0] i_div,
  output logic               o_tick
);

  logic [PRESC_W-1:0] r_cnt;

  // >= keeps the tick alive if the divisor is lowered mid-count
  assign o_tick = (r_cnt >= i_div);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wdt_ctrl.sv
// Watchdog controller: register port, prescaled counter, warn/bite FSM.
// Define WDT_WINDOW_EN to add the WINDOW register and window-kick check.
module wdt_ctrl
  import wdt_pkg::*;
#(
  parameter int          PRESC_W  = 16,
  parameter logic [31:0] KICK_KEY = KICK_KEY_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] count_o,
  output logic        ovf_o,
  output logic        irq_o,
  output logic        rst_req_o
);

  wdt_state_e         r_state;
  logic               r_en;
  logic               r_lock;
  logic               r_badkey;
  logic [PRESC_W-1:0] r_presc;
  logic [31:0]        r_load;
  logic [31:0]        r_count;
  logic               r_irq;
  logic               r_rst_req;
  logic               r_rvalid;
  logic [31:0]        r_rdata;

  logic        w_wr;
  logic        w_cfg_wr;
  logic        w_active;
  logic        w_kick_wr;
  logic        w_key_ok;
  logic        w_kick;
  logic        w_badkey;
  logic        w_tick;
  logic        w_ovf;
  logic        w_winviol;
  logic [31:0] w_presc32;
  logic [31:0] w_rdata;

  assign w_wr      = req_i & we_i;
  assign w_cfg_wr  = w_wr & ~r_lock;
  assign w_active  = (r_state == RUN) || (r_state == WARN);
  assign w_kick_wr = w_wr && (addr_i == ADDR_KICK) && w_active;
  assign w_key_ok  = (wdata_i == KICK_KEY);
  assign w_kick    = w_kick_wr & w_key_ok;
  assign w_badkey  = w_kick_wr & ~w_key_ok;
  // A kick landing on the wrap tick suppresses the overflow
  assign w_ovf     = w_active && w_tick && (r_count == 32'hFFFF_FFFF) && !w_kick;

`ifdef WDT_WINDOW_EN
  logic [31:0] r_window;

  assign w_winviol = w_kick && (r_state == RUN) &&
                     (r_window != 32'd0) && (r_count < r_window);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_window <= '0;
    end else if (w_cfg_wr && (addr_i == ADDR_WINDOW)) begin
      r_window <= wdata_i;
    end
  end
`else
  assign w_winviol = 1'b0;
`endif

  wdt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_clr  ((r_state == IDLE) || w_kick),
    .i_div  (r_presc),
    .o_tick (w_tick)
  );

  always_comb begin
    w_presc32 = '0;
    w_presc32[PRESC_W-1:0] = r_presc;
  end

  always_comb begin
    w_rdata = '0;
    case (addr_i)
      ADDR_CTRL:   w_rdata = {30'd0, r_lock, r_en};
      ADDR_PRESC:  w_rdata = w_presc32;
      ADDR_LOAD:   w_rdata = r_load;
      ADDR_STATUS: w_rdata = {29'd0, r_badkey, r_state};
      ADDR_COUNT:  w_rdata = r_count;
`ifdef WDT_WINDOW_EN
      ADDR_WINDOW: w_rdata = r_window;
`endif
      default:     w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en     <= 1'b0;
      r_lock   <= 1'b0;
      r_presc  <= '0;
      r_load   <= '0;
      r_badkey <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= (req_i && !we_i) ? w_rdata : 32'd0;
      if (w_cfg_wr && (addr_i == ADDR_CTRL)) begin
        r_en   <= wdata_i[CTRL_EN_BIT];
        r_lock <= wdata_i[CTRL_LOCK_BIT];
      end
      if (w_cfg_wr && (addr_i == ADDR_PRESC)) r_presc <= wdata_i[PRESC_W-1:0];
      if (w_cfg_wr && (addr_i == ADDR_LOAD)) r_load <= wdata_i;
      if (w_wr && (addr_i == ADDR_STATUS) && wdata_i[STAT_BADKEY_BIT]) begin
        r_badkey <= 1'b0;
      end else if (w_badkey) begin
        r_badkey <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_irq     <= 1'b0;
      r_rst_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (r_en) begin
            r_state <= RUN;
            r_count <= r_load;
          end
        end
        RUN: begin
          if (w_winviol) begin
            r_state   <= BITE;
            r_irq     <= 1'b1;
            r_rst_req <= 1'b1;
          end else if (w_kick) begin
            r_count <= r_load;
          end else if (w_ovf) begin
            r_state <= WARN;
            r_irq   <= 1'b1;
            r_count <= r_load;
          end else if (!r_en) begin
            r_state <= IDLE;
            r_count <= '0;
          end else if (w_tick) begin
            r_count <= r_count + 32'd1;
          end
        end
        WARN: begin
          if (w_kick) begin
            r_state <= RUN;
            r_irq   <= 1'b0;
            r_count <= r_load;
          end else if (w_ovf) begin
            r_state   <= BITE;
            r_rst_req <= 1'b1;
          end else if (!r_en) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
            r_count <= '0;
          end else if (w_tick) begin
            r_count <= r_count + 32'd1;
          end
        end
        BITE: begin
          r_irq     <= 1'b1;
          r_rst_req <= 1'b1;
        end
      endcase
    end
  end

  assign gnt_o     = req_i;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign count_o   = r_count;
  assign ovf_o     = w_ovf;
  assign irq_o     = r_irq;
  assign rst_req_o = r_rst_req;

endmodule
